// File: rtl/ram16x8_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the RAM16x8 array (32 words over two selects).
// Optional build macro RAM16X8_ARBITER_CLEAR_EN zero-fills all 32 words after reset release.
module ram16x8_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [3:0]        ram_bit,
  output logic              ram_write_enable,
  output logic              ram_select0,
  output logic              ram_select1,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_RESP
`ifdef RAM16X8_ARBITER_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

`ifdef RAM16X8_ARBITER_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t            state_q, state_d;
  logic              last_q, last_d;   // id granted most recently; 1 so requester 0 wins the first tie
  logic              gnt_q, gnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              win0, win1;
`ifdef RAM16X8_ARBITER_CLEAR_EN
  logic [4:0]        clr_q, clr_d;
`endif

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    gnt_d            = gnt_q;
    rdata_d          = rdata_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    rsp0_valid       = 1'b0;
    rsp1_valid       = 1'b0;
    ram_data_in      = '0;
    ram_bit          = '0;
    ram_write_enable = 1'b0;
    ram_select0      = 1'b0;
    ram_select1      = 1'b0;
    win0 = req0_valid && (!req1_valid || last_q);
    win1 = req1_valid && (!req0_valid || !last_q);
`ifdef RAM16X8_ARBITER_CLEAR_EN
    clr_d = clr_q;
`endif

    case (state_q)
      S_IDLE: begin
        req0_ready = win0;
        req1_ready = win1;
        if (win0) begin
          we_d    = req0_we;
          addr_d  = req0_addr;
          wdata_d = req0_wdata;
          gnt_d   = 1'b0;
          last_d  = 1'b0;
          state_d = S_ACCESS;
        end else if (win1) begin
          we_d    = req1_we;
          addr_d  = req1_addr;
          wdata_d = req1_wdata;
          gnt_d   = 1'b1;
          last_d  = 1'b1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ram_bit          = addr_q[3:0];
        ram_select1      = addr_q[ADDR_W-1];
        ram_select0      = ~addr_q[ADDR_W-1];
        ram_write_enable = we_q;
        ram_data_in      = wdata_q;
        state_d          = we_q ? S_RESP : S_CAPTURE;
      end
      S_CAPTURE: begin
        // Address and select stay put so the RAM output is stable when sampled.
        ram_bit     = addr_q[3:0];
        ram_select1 = addr_q[ADDR_W-1];
        ram_select0 = ~addr_q[ADDR_W-1];
        rdata_d     = ram_data_out;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~gnt_q;
        rsp1_valid = gnt_q;
        state_d    = S_IDLE;
      end
`ifdef RAM16X8_ARBITER_CLEAR_EN
      S_CLEAR: begin
        ram_bit          = clr_q[3:0];
        ram_select1      = clr_q[4];
        ram_select0      = ~clr_q[4];
        ram_write_enable = 1'b1;
        clr_d            = clr_q + 5'd1;
        if (clr_q == 5'd31) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef RAM16X8_ARBITER_CLEAR_EN
    // Reset parks the FSM in CLEAR; keep the RAM pins quiet until reset is released.
    if (!reset_n) begin
      ram_bit          = '0;
      ram_select0      = 1'b0;
      ram_select1      = 1'b0;
      ram_write_enable = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      rdata_q <= '0;
`ifdef RAM16X8_ARBITER_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
`ifdef RAM16X8_ARBITER_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Request payload is only meaningful after a grant, so it carries no reset.
  always_ff @(posedge clock) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign rsp_rdata = rdata_q;

endmodule
